// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default link constants
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_baud_cnt.sv
// Modulo-CLKS_PER_BIT bit-period counter with synchronous clear.
// tick is high on the last cycle of each bit period.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == CNT_MAX)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clr && (cnt == CNT_MAX);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts one word per valid/ready handshake and sends
// start bit, data LSB first, optional even parity, stop bit on a registered line.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_t          state;
  logic [DATA_BITS-1:0] shift_reg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 parity;
  logic                 tx_q;
  logic                 tick;

  // Bit timing restarts from zero on every accept because it is held clear in IDLE.
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == IDLE),
    .tick (tick)
  );

  // tx is loaded with the level of the upcoming bit on each transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_idx   <= '0;
      parity    <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (tx_valid) begin
            state     <= START;
            shift_reg <= tx_data;
            bit_idx   <= '0;
            parity    <= ^tx_data;
            tx_q      <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            tx_q  <= shift_reg[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_IDX) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx_q  <= parity;
              end else begin
                state <= STOP;
                tx_q  <= 1'b1;
              end
            end else begin
              shift_reg <= shift_reg >> 1;
              bit_idx   <= bit_idx + 1'b1;
              tx_q      <= shift_reg[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx_q  <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
            tx_q  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Parallel-to-serial UART transmitter. It accepts one data word per valid/ready handshake and shifts it out on a single line as a framed asynchronous serial character: start bit, data LSB first, optional even parity, then stop bit. It is the transmit end of the team's UART link. It pairs with the UART receiver/deserializer and connects to a host-side producer such as a register file or FIFO.

## Interface
Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal values are 2 or more.
- DATA_BITS, 8, payload width; legal range is 5 to 9.
- PARITY_EN, 0, when 1 an even-parity bit is inserted after the data bits.

Ports:
- clk  input  1  single system clock; all logic runs on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_valid  input  1  producer has a word on tx_data.
- tx_data  input  DATA_BITS  word to send; sampled only on the accept cycle.
- tx_ready  output  1  block can accept a word; high only in IDLE.
- tx  output  DATA_BITS-independent, 1  serial line, registered; idle level is 1.
- busy  output  1  a frame is in progress (any state other than IDLE).

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, tx_ready=1, busy=0.
  - On tx_valid=1, the word is accepted: tx_data is latched into the shift register, the bit counter and baud counter clear, and the FSM goes to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - tx = shift_reg[0], held CLKS_PER_BIT cycles per bit; then shift right and increment the bit index.
  - After bit DATA_BITS-1, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: tx = XOR of the latched word (even parity), held CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Counts 0 to CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
  - It wraps to 0 at each bit boundary. The bit advances on the wrap cycle.
- tx_data changes while busy are ignored. tx_valid while busy is not accepted and not queued.
- Reset (rst_n low, at any time including mid-frame):
  - tx=1, tx_ready=1, busy=0; FSM in IDLE; all counters and the shift register cleared.
  - Any partially sent frame is aborted.

## Timing
- Accept cycle: tx_valid && tx_ready at rising edge N. tx goes 0 and busy goes 1 after edge N (visible in cycle N+1).
- Frame length F = (2 + DATA_BITS + PARITY_EN) * CLKS_PER_BIT cycles, measured from the first start-bit cycle to the last stop-bit cycle.
- tx_ready rises in the cycle after the last stop-bit cycle.
- If tx_valid is held high, the next word is accepted in that IDLE cycle. Back-to-back frame start spacing is therefore F+1 cycles, with one extra idle-high cycle between frames.
- tx_ready, busy and tx are all registered or decoded from registered state. There is no combinational path from tx_valid to tx.
- Deassertion of rst_n is taken on the next rising clk edge. The block is in IDLE and ready on that edge.

## Structure
- Package uart_pkg holds:
  - typedef enum logic [2:0] uart_state_t {IDLE, START, DATA, PARITY, STOP}.
  - Default constants UART_CLKS_PER_BIT=16 and UART_DATA_BITS=8, shared with the receiver.
- Sub-module uart_baud_cnt: parameterised modulo-CLKS_PER_BIT counter with a clear input and a one-cycle tick output. It is reused by the receiver.
- The top holds the FSM, shift register, bit index and parity register.

## Test plan
- Reset then idle: hold rst_n=0 for 3 cycles, release → tx=1, tx_ready=1, busy=0; they stay so with tx_valid=0 for 50 cycles.
- Single frame, defaults (CLKS_PER_BIT=16, DATA_BITS=8, PARITY_EN=0):
  - Stimulus: send 0xA5.
  - Required tx, sampled mid-bit: 0, 1,0,1,0,0,1,0,1, 1.
  - busy high for exactly 160 cycles; tx_ready back high on cycle 161.
- Parity frame (PARITY_EN=1):
  - 0x07 → parity bit 1.
  - 0x03 → parity bit 0.
  - Frame length is 176 cycles.
- Back-to-back: tx_valid held with 0x55 then 0x0F → exactly one idle-high cycle between frames; both words are decoded correctly by a bench model.
- Busy rejection: pulse tx_valid with 0xFF mid-frame → no accept, no queuing; the current frame completes unchanged.
- Reset mid-frame: assert rst_n=0 during the DATA bit 3 period → tx=1 immediately (async). After release, a new word 0x3C sends cleanly.
